// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the Maxnet initiator and the Maxnet core.
package maxnet_pkg;

    localparam int W              = 5;
    localparam int N_INPUTS       = 4;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/maxnet_watchdog.sv
// WAIT-state cycle counter; compiled only when MAXNET_TIMEOUT_EN is defined.
`ifdef MAXNET_TIMEOUT_EN
module maxnet_watchdog #(
    parameter int TIMEOUT_CYCLES = maxnet_pkg::TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Expiry is the last permitted WAIT cycle, so the FSM leaves WAIT on the next edge.
    assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

    // Count WAIT cycles; cleared while the start pulse is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

endmodule
`endif

// File: rtl/maxnet_initiator.sv
// Maxnet initiator: packs four samples into X1..X4, pulses start, captures the result.
// Optional WAIT watchdog enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_initiator #(
    parameter int W = maxnet_pkg::W
`ifdef MAXNET_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = maxnet_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] X1,
    output logic [W-1:0] X2,
    output logic [W-1:0] X3,
    output logic [W-1:0] X4,
    output logic         start,
    input  logic         mx_done,
    input  logic [W-1:0] mx_result,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         timeout_err,
    output logic         busy
);

    import maxnet_pkg::*;

    state_t     state;
    logic [1:0] cnt;

`ifdef MAXNET_TIMEOUT_EN
    logic expired;

    maxnet_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == START),
        .count_en (state == WAIT),
        .expired  (expired)
    );
`endif

    // Control FSM; in_ready and busy are registered from the next-state decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            cnt         <= 2'd0;
            X1          <= '0;
            X2          <= '0;
            X3          <= '0;
            X4          <= '0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        case (cnt)
                            2'd0:    X1 <= in_data;
                            2'd1:    X2 <= in_data;
                            2'd2:    X3 <= in_data;
                            default: X4 <= in_data;
                        endcase
                        busy <= 1'b1;
                        if (cnt == 2'(N_INPUTS - 1)) begin
                            cnt      <= 2'd0;
                            state    <= START;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                START: begin
                    start <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A real result always wins over a simultaneous watchdog expiry.
                    if (mx_done) begin
                        out_data    <= mx_result;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= HOLD;
                    end
`ifdef MAXNET_TIMEOUT_EN
                    else if (expired) begin
                        out_data    <= '0;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= HOLD;
                    end
`endif
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid   <= 1'b0;
                        timeout_err <= 1'b0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= COLLECT;
                    end
                end
                default: begin
                    state       <= COLLECT;
                    cnt         <= 2'd0;
                    start       <= 1'b0;
                    out_valid   <= 1'b0;
                    timeout_err <= 1'b0;
                    in_ready    <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/maxnet_initiator.md
Name: maxnet_initiator

Overview:
- Initiator side of the Maxnet start/done interface.
- Accepts a serial stream of 5-bit samples and packs four of them into the X1..X4 operand registers.
- Issues a one-cycle start pulse, then waits for Maxnet's done and captures its result.
- Presents the result on a valid/ready output port. It sits between the upstream sample source and the Maxnet core.

Parameters:
- W, 5, sample and result width; matches Maxnet X1..X4 and result.
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_data  in  W  upstream sample.
- in_ready  out  1  block accepts a sample this cycle.
- X1, X2, X3, X4  out  W each  operand registers driven to Maxnet.
- start  out  1  one-cycle start pulse to Maxnet.
- mx_done  in  1  Maxnet done.
- mx_result  in  W  Maxnet result, valid while mx_done is high.
- out_valid  out  1  captured result valid.
- out_data  out  W  captured result.
- out_ready  in  1  downstream accepts the result.
- timeout_err  out  1  result was produced by the watchdog.
- busy  out  1  high in every state except COLLECT with cnt=0.

Behaviour:
- Reset values (asynchronous, active-high): state=COLLECT, cnt=0, X1..X4=0, start=0, out_valid=0, out_data=0, timeout_err=0, in_ready=1, busy=0.
- COLLECT:
  - in_ready=1.
  - A sample is accepted when in_valid&in_ready. It is written to X[cnt+1] (first accepted sample goes to X1), then cnt increments.
  - Accepting the 4th sample (cnt==3) moves to START next cycle and clears cnt.
- START:
  - start=1 for exactly this one cycle; in_ready=0.
  - Next state is WAIT, unconditionally. mx_done is ignored in this cycle.
- WAIT:
  - start=0, in_ready=0.
  - On mx_done=1: out_data<=mx_result, out_valid<=1, go to HOLD.
- HOLD:
  - out_valid=1; out_data is stable until out_valid&out_ready.
  - On that handshake: out_valid<=0, timeout_err<=0, return to COLLECT.
  - While in HOLD, mx_done is ignored and no new samples are accepted.
- X1..X4 change only on accepted samples in COLLECT. They are therefore stable from the start pulse until the block returns to COLLECT.
- Sample-to-start latency: start is asserted the cycle after the 4th sample is accepted.
- Done-to-out_valid latency: out_valid rises the cycle after mx_done is sampled in WAIT.
- Throughput: one Maxnet operation in flight at a time; no buffering beyond X1..X4 and out_data.
- Stalls: in_valid low in COLLECT holds cnt; out_ready low in HOLD stalls indefinitely.
- Reset at any time (including mid-collect, with start high, or in HOLD) returns all registers to their reset values immediately. A partially collected group is discarded.
- No arithmetic is performed; widths pass through at W bits.

Optional Feature:
- Macro: MAXNET_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter, reset on entry to WAIT, counts WAIT cycles.
  - If it reaches TIMEOUT_CYCLES with no mx_done, the block goes to HOLD with out_data=0, out_valid=1, timeout_err=1.
  - mx_done arriving in the same cycle as expiry takes priority: normal result, timeout_err=0.
- Without the macro: no counter; WAIT exits only on mx_done; timeout_err is tied 0.

Decomposition:
- Shared package maxnet_pkg:
  - W, state enum (COLLECT, START, WAIT, HOLD), default TIMEOUT_CYCLES.
  - Constant N_INPUTS=4, shared with Maxnet.
- Sub-module: none required. The watchdog counter may be a small sub-module, maxnet_watchdog, instantiated only under MAXNET_TIMEOUT_EN.

Test Plan:
- Reset, then feed 1,2,3,4 back-to-back: X1..X4=1,2,3,4; start high for exactly one cycle, the cycle after the 4th accept.
- Model asserts mx_done with mx_result=4 five cycles after start, out_ready=1: out_valid the next cycle with out_data=4; busy drops and in_ready=1 after the handshake.
- Gapped in_valid (1,0,1,0,...) for 5,9,2,7: cnt advances only on accepts; start fires only after 7; X registers unchanged during WAIT/HOLD.
- Hold out_ready=0 for 10 cycles after result 9: out_valid and out_data=9 stable; in_ready=0 throughout; in_valid pulses ignored.
- Assert rst after 2 samples, and again with start high: all outputs return to reset values asynchronously; the next 4 samples form a fresh group starting at X1.
- With MAXNET_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert mx_done: out_valid=1, out_data=0, timeout_err=1 after 8 WAIT cycles.
  - Repeat with mx_done on the expiry cycle: timeout_err=0, out_data=mx_result.
